// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: shadowed digit data, prescaled digit scan,
// registered one-hot anode drive. Optional leading-zero blanking via SEG_LEADING_ZERO_BLANK_EN.

module seg_digit_enc (
  input  logic [3:0] nib,
  input  logic       hex_mode,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b0000000;
    case (nib)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = hex_mode ? 7'b1110111 : 7'b0000000;
      4'hB: seg = hex_mode ? 7'b0011111 : 7'b0000000;
      4'hC: seg = hex_mode ? 7'b1001110 : 7'b0000000;
      4'hD: seg = hex_mode ? 7'b0111101 : 7'b0000000;
      4'hE: seg = hex_mode ? 7'b1001111 : 7'b0000000;
      4'hF: seg = hex_mode ? 7'b1000111 : 7'b0000000;
      default: seg = 7'b0000000;
    endcase
    if (blank) seg = 7'b0000000;
  end
endmodule

module seg_scan_driver #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   num,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  hex_mode,
  input  logic                  load,
  output logic [6:0]            codeout,
  output logic                  dpout,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  // XOR masks give the inactive level and the polarity flip in one place
  localparam logic [6:0]        SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = (ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]             pre;
  logic [IW-1:0]             idx;
  logic [DIGITS-1:0][3:0]    shadow_num;
  logic [DIGITS-1:0]         shadow_dp;
  logic [DIGITS-1:0][6:0]    seg_code;
  logic [DIGITS-1:0]         blank;
  logic [DIGITS-1:0]         an_nxt;
  logic                      pre_wrap;
  logic                      idx_wrap;

  assign pre_wrap = (pre == PW'(SCAN_DIV - 1));
  assign idx_wrap = (idx == IW'(DIGITS - 1));

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Blank digit i when it and every more-significant digit are zero; digit 0 always lit
  for (genvar i = 0; i < DIGITS; i++) begin : g_blank
    if (i == 0) begin : g_lsd
      assign blank[i] = 1'b0;
    end else begin : g_upper
      assign blank[i] = (shadow_num[DIGITS-1:i] == '0);
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    seg_digit_enc u_enc (
      .nib      (shadow_num[i]),
      .hex_mode (hex_mode),
      .blank    (blank[i]),
      .seg      (seg_code[i])
    );
  end

  always_comb begin
    an_nxt      = '0;
    an_nxt[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_num <= '0;
      shadow_dp  <= '0;
    end else if (load) begin
      shadow_num <= num;
      shadow_dp  <= dp;
    end
  end

  // Outputs sample the pre-edge shadow/index, so a load lands one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      pre        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
      codeout    <= SEG_OFF;
      dpout      <= DP_OFF;
      an         <= AN_OFF;
    end else begin
      pre        <= pre_wrap ? '0 : pre + 1'b1;
      if (pre_wrap) idx <= idx_wrap ? '0 : idx + 1'b1;
      frame_done <= pre_wrap && idx_wrap;
      codeout    <= seg_code[idx] ^ SEG_OFF;
      dpout      <= shadow_dp[idx] ^ DP_OFF;
      an         <= an_nxt ^ AN_OFF;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (DIGITS=4, SCAN_DIV=4), both polarities side by side.

module tb_seg_scan_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] num = '0;
  logic [3:0]  dp = '0;
  logic        hex_mode = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  codeout, codeout_al;
  logic        dpout, dpout_al;
  logic [3:0]  an, an_al;
  logic        frame_done, frame_done_al;

  int vecs = 0;
  int errs = 0;
  int ecnt = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst(rst), .num(num), .dp(dp), .hex_mode(hex_mode), .load(load),
    .codeout(codeout), .dpout(dpout), .an(an), .frame_done(frame_done)
  );

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1)) u_dut_al (
    .clk(clk), .rst(rst), .num(num), .dp(dp), .hex_mode(hex_mode), .load(load),
    .codeout(codeout_al), .dpout(dpout_al), .an(an_al), .frame_done(frame_done_al)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic run_to(input int k);
    while (ecnt < k) tick();
  endtask

  // Reset, then load at the release edge (E1). Outputs after Ek show digit ((k-1)/4)%4.
  task automatic start(input logic [15:0] n, input logic [3:0] d, input logic h);
    rst = 1'b1; load = 1'b0; hex_mode = h;
    tick(); tick();
    rst = 1'b0; load = 1'b1; num = n; dp = d;
    ecnt = 0;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    vecs++; if (an !== 4'b0000) begin errs++; $display("FAIL reset_an got %b exp %b", an, 4'b0000); end
    vecs++; if (codeout !== 7'b0000000) begin errs++; $display("FAIL reset_code got %b exp %b", codeout, 7'b0000000); end
    vecs++; if (dpout !== 1'b0 || frame_done !== 1'b0) begin errs++; $display("FAIL reset_dp_fd got %b%b exp 00", dpout, frame_done); end
    vecs++; if (an_al !== 4'b1111 || codeout_al !== 7'b1111111 || dpout_al !== 1'b1) begin
      errs++; $display("FAIL reset_al got an=%b code=%b dp=%b exp 1111 1111111 1", an_al, codeout_al, dpout_al);
    end
  endtask

  task automatic test_scan_1234();
    logic [6:0] ecode [4];
    logic [3:0] edp;
    ecode[0] = 7'b0110011; ecode[1] = 7'b1111001; ecode[2] = 7'b1101101; ecode[3] = 7'b0110000;
    edp = 4'b0101;
    start(16'h1234, edp, 1'b0);
    vecs++; if (an !== 4'b0001) begin errs++; $display("FAIL scan_first_an got %b exp 0001", an); end
    for (int k = 2; k <= 17; k++) begin
      int d;
      logic [3:0] ean;
      run_to(k);
      d = ((k - 1) / 4) % 4;
      ean = 4'b0001 << d;
      vecs++; if (an !== ean) begin errs++; $display("FAIL scan_an k=%0d got %b exp %b", k, an, ean); end
      vecs++; if (codeout !== ecode[d]) begin errs++; $display("FAIL scan_code k=%0d got %b exp %b", k, codeout, ecode[d]); end
      vecs++; if (dpout !== edp[d]) begin errs++; $display("FAIL scan_dp k=%0d got %b exp %b", k, dpout, edp[d]); end
    end
  endtask

  task automatic test_hex();
    logic [6:0] ecode [4];
    ecode[0] = 7'b0111101; ecode[1] = 7'b1001110; ecode[2] = 7'b0011111; ecode[3] = 7'b1110111;
    start(16'hABCD, 4'b0000, 1'b1);
    for (int d = 0; d < 4; d++) begin
      run_to(4 * d + 2);
      vecs++; if (codeout !== ecode[d]) begin errs++; $display("FAIL hex_on d=%0d got %b exp %b", d, codeout, ecode[d]); end
    end
    start(16'hABCD, 4'b0000, 1'b0);
    for (int d = 0; d < 4; d++) begin
      run_to(4 * d + 2);
      vecs++; if (codeout !== 7'b0000000) begin errs++; $display("FAIL hex_off d=%0d got %b exp 0000000", d, codeout); end
    end
  endtask

  task automatic test_leading_zero();
    logic [6:0] eup;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    eup = 7'b0000000;
`else
    eup = 7'b1111110;
`endif
    start(16'h0007, 4'b1000, 1'b0);
    run_to(2);
    vecs++; if (codeout !== 7'b1110000) begin errs++; $display("FAIL lz_d0 got %b exp 1110000", codeout); end
    for (int d = 1; d < 4; d++) begin
      run_to(4 * d + 2);
      vecs++; if (codeout !== eup) begin errs++; $display("FAIL lz_d%0d got %b exp %b", d, codeout, eup); end
    end
    vecs++; if (dpout !== 1'b1) begin errs++; $display("FAIL lz_dp got %b exp 1", dpout); end
  endtask

  task automatic test_frame_done();
    start(16'h1234, 4'b0000, 1'b0);
    vecs++; if (frame_done !== 1'b0) begin errs++; $display("FAIL fd_k1 got %b exp 0", frame_done); end
    for (int k = 2; k <= 40; k++) begin
      logic efd;
      run_to(k);
      efd = (k % 16 == 0);
      vecs++; if (frame_done !== efd) begin errs++; $display("FAIL fd k=%0d got %b exp %b", k, frame_done, efd); end
    end
  endtask

  task automatic test_rst_midframe();
    start(16'h1234, 4'b0000, 1'b0);
    run_to(9);
    vecs++; if (an !== 4'b0100) begin errs++; $display("FAIL mid_pre_an got %b exp 0100", an); end
    rst = 1'b1;
    tick();
    vecs++; if (an !== 4'b0000 || frame_done !== 1'b0) begin
      errs++; $display("FAIL mid_rst got an=%b fd=%b exp 0000 0", an, frame_done);
    end
    rst = 1'b0;
    for (int r = 1; r <= 16; r++) begin
      logic [3:0] ean;
      logic efd;
      tick();
      ean = 4'b0001 << ((r - 1) / 4);
      efd = (r == 16);
      vecs++; if (an !== ean) begin errs++; $display("FAIL mid_an r=%0d got %b exp %b", r, an, ean); end
      vecs++; if (frame_done !== efd) begin errs++; $display("FAIL mid_fd r=%0d got %b exp %b", r, frame_done, efd); end
      if (r <= 4) begin
        vecs++; if (codeout !== 7'b1111110) begin errs++; $display("FAIL mid_code r=%0d got %b exp 1111110", r, codeout); end
      end
    end
  endtask

  task automatic test_back_to_back();
    start(16'h1111, 4'b0000, 1'b0);
    run_to(7);
    load = 1'b1; num = 16'h2222;
    tick();
    load = 1'b0;
    vecs++; if (an !== 4'b0010 || codeout !== 7'b0110000) begin
      errs++; $display("FAIL b2b_old got an=%b code=%b exp 0010 0110000", an, codeout);
    end
    tick();
    vecs++; if (an !== 4'b0100 || codeout !== 7'b1101101) begin
      errs++; $display("FAIL b2b_new got an=%b code=%b exp 0100 1101101", an, codeout);
    end
  endtask

  task automatic test_active_low();
    start(16'h8888, 4'b0001, 1'b0);
    run_to(2);
    vecs++; if (codeout_al !== 7'b0000000) begin errs++; $display("FAIL al_code got %b exp 0000000", codeout_al); end
    vecs++; if (dpout_al !== 1'b0) begin errs++; $display("FAIL al_dp got %b exp 0", dpout_al); end
    vecs++; if (an_al !== 4'b1110) begin errs++; $display("FAIL al_an got %b exp 1110", an_al); end
    vecs++; if (codeout !== 7'b1111111 || dpout !== 1'b1) begin
      errs++; $display("FAIL al_ref got code=%b dp=%b exp 1111111 1", codeout, dpout);
    end
    run_to(6);
    vecs++; if (dpout_al !== 1'b1 || an_al !== 4'b1101) begin
      errs++; $display("FAIL al_d1 got dp=%b an=%b exp 1 1101", dpout_al, an_al);
    end
  endtask

  initial begin
    test_reset();
    test_scan_1234();
    test_hex();
    test_leading_zero();
    test_frame_done();
    test_rst_midframe();
    test_back_to_back();
    test_active_low();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed 7-segment digits (1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 50000: clk cycles each digit is enabled (>=2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 0: 1 inverts codeout, dpout and an.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port num  input  4*DIGITS  packed nibbles, digit i = num[4i+3:4i], digit 0 least significant.
REQ-007 SHALL have port dp  input  DIGITS  decimal point request per digit.
REQ-008 SHALL have port hex_mode  input  1  1 = nibbles 10-15 shown as A-F; 0 = shown blank.
REQ-009 SHALL have port load  input  1  capture num/dp into shadow register.
REQ-010 SHALL have port codeout  output  7  segments {a,b,c,d,e,f,g}, MSB = a, registered.
REQ-011 SHALL have port dpout  output  1  decimal point of active digit, registered.
REQ-012 SHALL have port an  output  DIGITS  one-hot digit enable, registered.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse per completed scan frame.

Function
REQ-014 SHALL capture num and dp into shadow on any clk edge with load=1; display SHALL use shadow only.
REQ-015 SHALL count prescaler 0..SCAN_DIV-1; at SCAN_DIV-1 prescaler wraps to 0 and digit index advances, DIGITS-1 wrapping to 0.
REQ-016 SHALL drive codeout/dpout/an from shadow[index] and index with one cycle registered latency; load at edge t is visible on codeout after edge t+1.
REQ-017 SHALL encode (active-high) 0:1111110 1:0110000 2:1101101 3:1111001 4:0110011 5:1011011 6:1011111 7:1110000 8:1111111 9:1111011.
REQ-018 SHALL encode with hex_mode=1 A:1110111 b:0011111 C:1001110 d:0111101 E:1001111 F:1000111; with hex_mode=0 nibbles 10-15 SHALL give 0000000.
REQ-019 SHALL pulse frame_done for exactly one cycle on the edge where index wraps DIGITS-1 -> 0.
REQ-020 SHALL, when load coincides with index advance, display the newly loaded shadow value for the new digit.
REQ-021 SHALL keep an strictly one-hot (zero-hot only during reset), never two digits enabled in one cycle.
REQ-022 SHALL apply ACTIVE_LOW inversion after all encoding and blanking.

Reset
REQ-023 SHALL on rst=1 clear prescaler, index to 0, shadow to 0, frame_done to 0.
REQ-024 SHALL during reset drive codeout, dpout and an to the inactive level (all segments and digits off).
REQ-025 SHALL, on rst asserted mid-frame, abandon the frame and restart at digit 0 with full SCAN_DIV dwell, no frame_done pulse.

Configuration
REQ-026 SHALL with macro SEG_LEADING_ZERO_BLANK_EN defined blank (codeout 0000000) every digit whose value and all more-significant digit values are 0, except digit 0 always shown; dpout unaffected.
REQ-027 SHALL without SEG_LEADING_ZERO_BLANK_EN display every digit per REQ-017/018.

Verification (DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=0 unless stated)
REQ-028 SHALL cover: reset, load num=16'h1234 -> an 0001,0010,0100,1000 each 4 cycles; codeout 0110011 at an=0001, 0110000 at an=1000.
REQ-029 SHALL cover: hex_mode=1, num=16'hABCD -> codeout 0111101 at an=0001, 1110111 at an=1000; hex_mode=0 same num -> all digits 0000000.
REQ-030 SHALL cover: num=16'h0007 -> with SEG_LEADING_ZERO_BLANK_EN digits 3..1 0000000, digit 0 1110000; without macro digits 3..1 1111110.
REQ-031 SHALL cover: free run -> frame_done high one cycle every 16 cycles; rst at index 2 -> an=0000 next cycle, no pulse, restart at digit 0.
REQ-032 SHALL cover: load asserted on the advance edge with num changing 16'h1111 -> 16'h2222 -> new digit shows 1101101.
REQ-033 SHALL cover: ACTIVE_LOW=1, num=16'h8888, dp=4'b0001 -> codeout 0000000, dpout 0 at active digit 0, active an bit 0.
